spi_main: RTL

SPI_MAIN -- requirements
Module: spi_main

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_shreg.sv | 28 ++
 rtl/spi_main.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, opcodes and state encoding for the SPI main
package spi_pkg;

    localparam int FRAME_W = 44;
    localparam int OP_W    = 2;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int HDR_W   = OP_W + ADDR_W;

    // Bit counter restarts here on every state entry (index of the frame MSB).
    localparam logic [5:0] CNT_RELOAD = 6'(FRAME_W - 1);

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX   = 3'd1,
        TURN = 3'd2,
        RX   = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/spi_shreg.sv
// rtl/spi_shreg.sv - 44-bit load/shift register, MSB out first, shared by TX and RX
module spi_shreg
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [FRAME_W-1:0] load_data_i,
    input  logic               shift_in_i,
    output logic [FRAME_W-1:0] q_o
);

    logic [FRAME_W-1:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= load_data_i;
        end else if (shift_i) begin
            sh_q <= {sh_q[FRAME_W-2:0], shift_in_i};
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/spi_main.sv
// rtl/spi_main.sv - SPI main: 44-bit request out, turnaround, 44-bit response in
// Response header check is built only with SPI_MAIN_CHECK_EN defined.
module spi_main
    import spi_pkg::*;
#(
    parameter int TURN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              abort,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    // TURN counts down from the reload value and leaves after TURN_CYCLES periods.
    localparam logic [5:0] CNT_TURN_LAST = 6'(FRAME_W - TURN_CYCLES);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               ph_q, ph_d;
    logic               lead_q, lead_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               sh_load, sh_shift;
    logic [FRAME_W-1:0] sh_q;
`ifdef SPI_MAIN_CHECK_EN
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic               err_q, err_d;
`else
    logic               unused_hdr;
    assign unused_hdr = ^sh_q[FRAME_W-3:DATA_W];
`endif

    spi_shreg u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (sh_load),
        .shift_i    (sh_shift),
        .load_data_i({op, addr, wdata}),
        .shift_in_i (miso),
        .q_o        (sh_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_RELOAD;
            ph_q    <= 1'b0;
            lead_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rdata_q <= '0;
`ifdef SPI_MAIN_CHECK_EN
            hdr_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            lead_q  <= lead_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            rdata_q <= rdata_d;
`ifdef SPI_MAIN_CHECK_EN
            hdr_q   <= hdr_d;
            err_q   <= err_d;
`endif
        end
    end

    // ph_q=0 is the sclk-low half of a period, ph_q=1 the high half.
    // lead_q is the single clk after acceptance before cs_n drops with bit 43.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        lead_d   = lead_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        rdata_d  = rdata_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
`ifdef SPI_MAIN_CHECK_EN
        hdr_d    = hdr_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start) begin
                    sh_load = 1'b1;
                    state_d = TX;
                    cnt_d   = CNT_RELOAD;
                    ph_d    = 1'b0;
                    lead_d  = 1'b1;
`ifdef SPI_MAIN_CHECK_EN
                    hdr_d   = {op, addr};
`endif
                end
            end
            TX: begin
                if (lead_q) begin
                    lead_d = 1'b0;
                    cs_n_d = 1'b0;
                    sclk_d = 1'b0;
                    mosi_d = sh_q[FRAME_W-1];
                end else if (!ph_q) begin
                    sclk_d = 1'b1;
                    ph_d   = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    ph_d   = 1'b0;
                    if (cnt_q == 6'd0) begin
                        state_d = TURN;
                        cnt_d   = CNT_RELOAD;
                        mosi_d  = 1'b0;
                    end else begin
                        sh_shift = 1'b1;
                        mosi_d   = sh_q[FRAME_W-2];
                        cnt_d    = cnt_q - 6'd1;
                    end
                end
            end
            TURN: begin
                if (!ph_q) begin
                    sclk_d = 1'b1;
                    ph_d   = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    ph_d   = 1'b0;
                    if (cnt_q == CNT_TURN_LAST) begin
                        state_d = RX;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            RX: begin
                if (!ph_q) begin
                    sclk_d   = 1'b1;
                    ph_d     = 1'b1;
                    sh_shift = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    ph_d   = 1'b0;
                    if (cnt_q == 6'd0) begin
                        state_d = DONE;
                        cs_n_d  = 1'b1;
                        rdata_d = sh_q[DATA_W-1:0];
`ifdef SPI_MAIN_CHECK_EN
                        err_d   = (sh_q[FRAME_W-1:DATA_W] != hdr_q);
`endif
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort beats whatever the active states decided this cycle.
        if (abort && (state_q == TX || state_q == TURN || state_q == RX)) begin
            state_d  = IDLE;
            cs_n_d   = 1'b1;
            sclk_d   = 1'b0;
            mosi_d   = 1'b0;
            ph_d     = 1'b0;
            lead_d   = 1'b0;
            sh_shift = 1'b0;
            rdata_d  = rdata_q;
`ifdef SPI_MAIN_CHECK_EN
            err_d    = err_q;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign cs_n  = cs_n_q;
    assign mosi  = mosi_q;
`ifdef SPI_MAIN_CHECK_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule
